// File: rtl/bcd_share_sched.sv
// Shared double-dabble binary-to-BCD converter serving two requesters.
// Round-robin accept in IDLE, 16 shift-add-3 steps, then a registered result with per-owner done.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bcd_share_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] bin0,
  input  logic        req1,
  input  logic [15:0] bin1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic [15:0] bcd_out,
  output logic        ovf,
  output logic        done0,
  output logic        done1
);
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                       state_q;
  logic [15:0]                  sr_q, sr_d;
  logic [NUM_DIGITS-1:0][3:0]   dig_q, adj, dig_d;
  logic [3:0]                   cnt_q;
  logic                         owner_q, last_q, ovf_pend_q;
  logic                         gnt0_q, gnt1_q, done0_q, done1_q, busy_q, ovf_q;
  logic [15:0]                  bcd_q;
  logic                         win;
  logic [15:0]                  op;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (.d_i(dig_q[g]), .d_o(adj[g]));
  end

  // Digit chain shifts left as one 16-bit word with the operand MSB entering ones[0].
  // The bit leaving the thousands digit recirculates into the operand LSB; it can
  // never reach the operand MSB within 16 shifts, so it never re-enters the digits.
  assign dig_d = {adj[3][2:0], adj[2], adj[1], adj[0], sr_q[15]};
  assign sr_d  = {sr_q[14:0], adj[3][3]};

  // Tie goes to whichever requester was not served last.
  assign win = (req0 && req1) ? ~last_q : req1;
  assign op  = win ? bin1 : bin0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      ovf_pend_q <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            sr_q       <= op;
            owner_q    <= win;
            last_q     <= win;
            ovf_pend_q <= (op > 16'd9999);
            dig_q      <= '0;
            cnt_q      <= '0;
            gnt0_q     <= ~win;
            gnt1_q     <= win;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          dig_q <= dig_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= S_DONE;
        end
        S_DONE: begin
          bcd_q   <= ovf_pend_q ? 16'h9999 : dig_q;
          ovf_q   <= ovf_pend_q;
          done0_q <= ~owner_q;
          done1_q <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
endmodule

// File: tb/tb_bcd_share_sched.sv
// Scoreboard bench for bcd_share_sched: stimulus predicts owner/result with a decimal
// model and queues it; a monitor checks each done pulse against the queue.
module tb_bcd_share_sched;
  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [15:0] bin0, bin1;
  logic        gnt0, gnt1, busy, ovf, done0, done1;
  logic [15:0] bcd_out;

  bcd_share_sched dut (
    .clk(clk), .rst(rst),
    .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .bcd_out(bcd_out), .ovf(ovf), .done0(done0), .done1(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          own;
    logic [15:0] bcd;
    bit          ovf;
  } exp_t;

  exp_t        sbq[$];
  int          gq[$];
  int          vectors = 0, errors = 0;
  logic [15:0] last_bcd = 16'h0000;
  bit          last_ovf = 1'b0;
  bit          m_last = 1'b1;
  int          prev_gnt = 0;

  function automatic logic [15:0] to_bcd(input logic [15:0] v);
    int vi;
    vi = int'(v);
    if (vi > 9999) return 16'h9999;
    return {4'(vi / 1000), 4'((vi / 100) % 10), 4'((vi / 10) % 10), 4'(vi % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: exclusivity, done-vs-scoreboard, latency, and result hold between dones.
  always @(negedge clk) begin : mon
    exp_t e;
    int   gc;
    if (!rst) begin
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        vectors++; errors++;
        $display("FAIL exclusive: gnt=%b%b done=%b%b", gnt0, gnt1, done0, done1);
      end
      if (done0 || done1) begin
        if (sbq.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_done: done0=%b done1=%b with empty scoreboard", done0, done1);
        end else begin
          e  = sbq.pop_front();
          gc = (gq.size() != 0) ? gq.pop_front() : -100;
          chk("done_owner", {31'd0, done1}, {31'd0, e.own});
          chk("bcd_out", {16'd0, bcd_out}, {16'd0, e.bcd});
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          chk("done_latency", cyc - gc, 17);
          last_bcd = e.bcd;
          last_ovf = e.ovf;
        end
      end else if (bcd_out !== last_bcd || ovf !== last_ovf) begin
        vectors++; errors++;
        $display("FAIL result_hold: bcd_out=%h ovf=%b expected %h/%b", bcd_out, ovf, last_bcd, last_ovf);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    sbq.delete(); gq.delete();
    last_bcd = 16'h0000; last_ovf = 1'b0; m_last = 1'b1;
    #1;
    chk("reset_outputs", {10'd0, gnt0, gnt1, done0, done1, busy, ovf, bcd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve(input bit r0, input logic [15:0] b0, input bit r1,
                       input logic [15:0] b1, input bit drop, input int spacing);
    bit   w, got;
    exp_t e;
    req0 = r0; bin0 = b0; req1 = r1; bin1 = b1;
    w = (r0 && r1) ? !m_last : r1;
    m_last = w;
    e.own = w;
    e.bcd = to_bcd(w ? b1 : b0);
    e.ovf = ((w ? b1 : b0) > 16'd9999);
    sbq.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) got = 1'b1;
    end
    if (!got) begin
      vectors++; errors++;
      $display("FAIL gnt_timeout: no grant within 40 cycles (req=%b%b)", r0, r1);
      void'(sbq.pop_back());
    end else begin
      chk("gnt_owner", {30'd0, gnt0, gnt1}, w ? 32'd1 : 32'd2);
      chk("busy_with_gnt", {31'd0, busy}, 32'd1);
      if (spacing > 0) chk("gnt_spacing", cyc - prev_gnt, spacing);
      prev_gnt = cyc;
      gq.push_back(cyc);
      if (drop) begin
        if (w) req1 = 1'b0;
        else   req0 = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] bnd[8];
    int          mode;
    logic [15:0] rb0, rb1;
    bnd = '{16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd4095};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    @(negedge clk);
    do_reset();

    serve(1'b1, 16'd1234, 1'b0, 16'd0, 1'b1, 0);
    drain();
    do_reset();

    // Simultaneous requests after reset: requester 0 first, requester 1 18 cycles later.
    serve(1'b1, 16'd0, 1'b1, 16'd9999, 1'b1, 0);
    serve(1'b0, 16'd0, 1'b1, 16'd9999, 1'b1, 18);

    serve(1'b0, 16'd0, 1'b1, 16'd10000, 1'b1, 0);
    serve(1'b0, 16'd0, 1'b1, 16'hFFFF, 1'b1, 0);
    serve(1'b0, 16'd0, 1'b1, 16'd42, 1'b1, 0);

    for (int i = 0; i < 8; i++)
      serve(!i[0], bnd[i], i[0], bnd[i], 1'b1, 0);

    serve(1'b0, 16'd0, 1'b1, 16'hFFFF, 1'b1, 0);
    drain();

    // Reset during the 8th shift cycle drops the conversion silently.
    serve(1'b1, 16'd5678, 1'b0, 16'd0, 1'b1, 0);
    repeat (7) @(negedge clk);
    do_reset();
    repeat (25) @(negedge clk);
    serve(1'b1, 16'd5678, 1'b0, 16'd0, 1'b1, 0);
    drain();

    // Both held high: alternating grants at 18-cycle spacing.
    serve(1'b1, 16'd321, 1'b1, 16'd8765, 1'b0, 0);
    serve(1'b1, 16'd321, 1'b1, 16'd8765, 1'b0, 18);
    serve(1'b1, 16'd321, 1'b1, 16'd8765, 1'b0, 18);
    serve(1'b1, 16'd321, 1'b1, 16'd8765, 1'b0, 18);
    req0 = 1'b0; req1 = 1'b0;
    drain();

    for (int k = 0; k < 24; k++) begin
      mode = int'($urandom_range(0, 2));
      rb0 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
      rb1 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
      serve(mode != 1, rb0, mode != 0, rb1, 1'b1, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    drain();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
